// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - command encoding and reset constants for the parametrised LIFO stack
package stack_pkg;

   typedef enum logic [1:0] {
      CMD_NOP  = 2'b00,
      CMD_PUSH = 2'b01,
      CMD_POP  = 2'b10,
      CMD_GET  = 2'b11
   } stack_cmd_e;

   localparam int unsigned RST_PTR   = 0;
   localparam int unsigned RST_COUNT = 0;
   localparam logic        RST_VALID = 1'b0;
   localparam logic        RST_ERROR = 1'b0;

endpackage

// File: rtl/stack_ptr_wrap.sv
// rtl/stack_ptr_wrap.sv - modulo-DEPTH increment, decrement and subtract for stack pointers
module stack_ptr_wrap #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic [AW-1:0] ptr,
   input  logic [AW-1:0] offset,
   output logic [AW-1:0] ptr_inc,
   output logic [AW-1:0] ptr_dec,
   output logic [AW-1:0] ptr_sub
);

   localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

   logic [AW:0] ptr_ext;
   logic [AW:0] off_ext;

   assign ptr_ext = {1'b0, ptr};
   assign off_ext = {1'b0, offset};

   // Explicit wrap instead of bit truncation so non-power-of-2 depths work.
   assign ptr_inc = (ptr == LAST) ? '0 : ptr + AW'(1);
   assign ptr_dec = (ptr == '0) ? LAST : ptr - AW'(1);
   assign ptr_sub = (ptr >= offset) ? ptr - offset : AW'(ptr_ext + DEPTH_EXT - off_ext);

endmodule

// File: rtl/stack_behaviour_param.sv
// rtl/stack_behaviour_param.sv - LIFO stack with push/pop/get; STACK_STICKY_ERR_EN makes ERROR sticky
module stack_behaviour_param
   import stack_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 8,
   parameter int OVERWRITE = 0
) (
   input  logic                       CLK,
   input  logic                       RESET_N,
   input  logic [1:0]                 COMMAND,
   input  logic [$clog2(DEPTH)-1:0]   INDEX,
   input  logic [WIDTH-1:0]           I_DATA,
   output logic [WIDTH-1:0]           O_DATA,
   output logic                       O_VALID,
   output logic                       FULL,
   output logic                       EMPTY,
   output logic [$clog2(DEPTH+1)-1:0] COUNT,
   output logic                       ERROR
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   stack_cmd_e cmd;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             mem_we;

   logic [AW-1:0]    tp_q, tp_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] o_data_q, o_data_d;
   logic             o_valid_q, o_valid_d;
   logic             error_q, error_d;
   logic             err_op;

   logic [AW-1:0]    tp_inc, tp_dec, get_addr;
   logic             full, empty;
   logic [CW-1:0]    index_ext;

   assign cmd       = stack_cmd_e'(COMMAND);
   assign full      = (count_q == DEPTH_C);
   assign empty     = (count_q == '0);
   assign index_ext = CW'(INDEX);

   stack_ptr_wrap #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ptr_wrap (
      .ptr     (tp_q),
      .offset  (INDEX),
      .ptr_inc (tp_inc),
      .ptr_dec (tp_dec),
      .ptr_sub (get_addr)
   );

   always_comb begin
      tp_d      = tp_q;
      count_d   = count_q;
      o_data_d  = o_data_q;
      o_valid_d = 1'b0;
      mem_we    = 1'b0;
      err_op    = 1'b0;
      case (cmd)
         CMD_PUSH: begin
            if (!full || (OVERWRITE != 0)) begin
               tp_d   = tp_inc;
               mem_we = 1'b1;
               if (!full) count_d = count_q + CW'(1);
            end else begin
               err_op = 1'b1;
            end
         end
         CMD_POP: begin
            if (!empty) begin
               o_data_d  = mem_q[tp_q];
               o_valid_d = 1'b1;
               tp_d      = tp_dec;
               count_d   = count_q - CW'(1);
            end else begin
               err_op = 1'b1;
            end
         end
         CMD_GET: begin
            if (index_ext < count_q) begin
               o_data_d  = mem_q[get_addr];
               o_valid_d = 1'b1;
            end else begin
               err_op = 1'b1;
            end
         end
         default: ;
      endcase
`ifdef STACK_STICKY_ERR_EN
      error_d = error_q | err_op;
`else
      error_d = err_op;
`endif
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         tp_q      <= AW'(RST_PTR);
         count_q   <= CW'(RST_COUNT);
         o_data_q  <= '0;
         o_valid_q <= RST_VALID;
         error_q   <= RST_ERROR;
      end else begin
         tp_q      <= tp_d;
         count_q   <= count_d;
         o_data_q  <= o_data_d;
         o_valid_q <= o_valid_d;
         error_q   <= error_d;
      end
   end

   // Storage has no reset; count gating keeps stale entries unreadable.
   always_ff @(posedge CLK) begin
      if (RESET_N && mem_we) mem_q[tp_d] <= I_DATA;
   end

   assign O_DATA  = o_data_q;
   assign O_VALID = o_valid_q;
   assign FULL    = full;
   assign EMPTY   = empty;
   assign COUNT   = count_q;
   assign ERROR   = error_q;

endmodule

// File: tb/tb_stack_behaviour_param.sv
// tb/tb_stack_behaviour_param.sv - bench for three stack configurations against a shift-array model
module tb_stack_behaviour_param;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic [1:0] COMMAND = 2'b00;
   logic [2:0] INDEX = 3'd0;
   logic [3:0] I_DATA = 4'd0;

   logic [3:0] od0, od1, od2;
   logic       ov0, ov1, ov2, fu0, fu1, fu2, em0, em1, em2, er0, er1, er2;
   logic [3:0] ct0, ct1;
   logic [2:0] ct2;

   int asserts = 0;
   int fails   = 0;

   always #5 CLK = ~CLK;

   stack_behaviour_param #(.WIDTH(4), .DEPTH(8), .OVERWRITE(0)) u_ow0 (
      .CLK(CLK), .RESET_N(RESET_N), .COMMAND(COMMAND), .INDEX(INDEX), .I_DATA(I_DATA),
      .O_DATA(od0), .O_VALID(ov0), .FULL(fu0), .EMPTY(em0), .COUNT(ct0), .ERROR(er0));

   stack_behaviour_param #(.WIDTH(4), .DEPTH(8), .OVERWRITE(1)) u_ow1 (
      .CLK(CLK), .RESET_N(RESET_N), .COMMAND(COMMAND), .INDEX(INDEX), .I_DATA(I_DATA),
      .O_DATA(od1), .O_VALID(ov1), .FULL(fu1), .EMPTY(em1), .COUNT(ct1), .ERROR(er1));

   stack_behaviour_param #(.WIDTH(4), .DEPTH(5), .OVERWRITE(0)) u_d5 (
      .CLK(CLK), .RESET_N(RESET_N), .COMMAND(COMMAND), .INDEX(INDEX), .I_DATA(I_DATA),
      .O_DATA(od2), .O_VALID(ov2), .FULL(fu2), .EMPTY(em2), .COUNT(ct2), .ERROR(er2));

   // Reference: element 0 is the top of stack; push shifts everything down.
   int         dep [3] = '{8, 8, 5};
   int         ow  [3] = '{0, 1, 0};
   int         cnt [3];
   logic [3:0] st  [3][8];
   logic [3:0] ed  [3];
   logic       ev  [3];
   logic       ee  [3];

   task automatic chk(input string tag, input int m, input logic [31:0] act, input logic [31:0] exp);
      asserts++;
      assert (act === exp) else begin
         fails++;
         $error("FAIL %s dut%0d: got %0h expected %0h", tag, m, act, exp);
      end
   endtask

   task automatic model(input logic rn, input logic [1:0] c, input logic [2:0] idx, input logic [3:0] d);
      logic err;
      for (int m = 0; m < 3; m++) begin
         if (!rn) begin
            cnt[m] = 0; ed[m] = 4'd0; ev[m] = 1'b0; ee[m] = 1'b0;
         end else begin
            err = 1'b0;
            ev[m] = 1'b0;
            case (c)
               2'd1: begin
                  if (cnt[m] < dep[m] || ow[m] == 1) begin
                     for (int i = dep[m] - 1; i > 0; i--) st[m][i] = st[m][i-1];
                     st[m][0] = d;
                     if (cnt[m] < dep[m]) cnt[m]++;
                  end else err = 1'b1;
               end
               2'd2: begin
                  if (cnt[m] > 0) begin
                     ed[m] = st[m][0]; ev[m] = 1'b1;
                     for (int i = 0; i < dep[m] - 1; i++) st[m][i] = st[m][i+1];
                     cnt[m]--;
                  end else err = 1'b1;
               end
               2'd3: begin
                  if (int'(idx) < cnt[m]) begin
                     ed[m] = st[m][idx]; ev[m] = 1'b1;
                  end else err = 1'b1;
               end
               default: ;
            endcase
`ifdef STACK_STICKY_ERR_EN
            ee[m] = ee[m] | err;
`else
            ee[m] = err;
`endif
         end
      end
   endtask

   task automatic check_all();
      logic [3:0] a_d [3];
      logic       a_v [3], a_f [3], a_e [3], a_r [3];
      int         a_c [3];
      a_d = '{od0, od1, od2};
      a_v = '{ov0, ov1, ov2};
      a_f = '{fu0, fu1, fu2};
      a_e = '{em0, em1, em2};
      a_r = '{er0, er1, er2};
      a_c = '{int'(ct0), int'(ct1), int'(ct2)};
      for (int m = 0; m < 3; m++) begin
         chk("o_data",  m, 32'(a_d[m]), 32'(ed[m]));
         chk("o_valid", m, 32'(a_v[m]), 32'(ev[m]));
         chk("count",   m, 32'(a_c[m]), 32'(cnt[m]));
         chk("full",    m, 32'(a_f[m]), 32'(cnt[m] == dep[m]));
         chk("empty",   m, 32'(a_e[m]), 32'(cnt[m] == 0));
         chk("error",   m, 32'(a_r[m]), 32'(ee[m]));
      end
   endtask

   task automatic step(input logic rn, input logic [1:0] c, input logic [2:0] idx, input logic [3:0] d);
      RESET_N = rn; COMMAND = c; INDEX = idx; I_DATA = d;
      @(posedge CLK);
      model(rn, c, idx, d);
      #1;
      check_all();
   endtask

   initial begin
      step(1'b0, 2'd0, 3'd0, 4'd0);
      step(1'b0, 2'd1, 3'd0, 4'd9);
      // push 1,2,3 then pop all three
      for (int i = 1; i <= 3; i++) step(1'b1, 2'd1, 3'd0, 4'(i));
      for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 3'd0, 4'd0);
      // push A,B,C then GET 0..3
      for (int i = 10; i <= 12; i++) step(1'b1, 2'd1, 3'd0, 4'(i));
      for (int i = 0; i <= 3; i++) step(1'b1, 2'd3, 3'(i), 4'd0);
      step(1'b1, 2'd0, 3'd0, 4'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 3'd0, 4'd0);
      step(1'b1, 2'd2, 3'd0, 4'd0);
      step(1'b1, 2'd0, 3'd0, 4'd0);
      step(1'b0, 2'd0, 3'd0, 4'd0);
      // fill past full, then push 0xF and drain
      for (int i = 0; i <= 9; i++) step(1'b1, 2'd1, 3'd0, 4'(i));
      step(1'b1, 2'd1, 3'd0, 4'hF);
      step(1'b1, 2'd3, 3'd7, 4'd0);
      step(1'b1, 2'd3, 3'd4, 4'd0);
      for (int i = 0; i < 9; i++) step(1'b1, 2'd2, 3'd0, 4'd0);
      // reset coinciding with a push, mid-sequence
      for (int i = 1; i <= 6; i++) step(1'b1, 2'd1, 3'd0, 4'(i));
      step(1'b0, 2'd1, 3'd0, 4'hE);
      step(1'b1, 2'd3, 3'd0, 4'd0);
      step(1'b1, 2'd2, 3'd0, 4'd0);
      // randomised traffic with occasional reset
      for (int n = 0; n < 600; n++) begin
         logic [1:0] c;
         c = ($urandom_range(0, 9) < 4) ? 2'd1 : 2'($urandom_range(0, 3));
         step(($urandom_range(0, 60) != 0), c, 3'($urandom_range(0, 7)), 4'($urandom));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
